// File: rtl/fpga1_pkg.sv
// Shared types and constants for the data-matrix frame assembler.
package fpga1_pkg;

    typedef enum logic [2:0] {IDLE, COLLECT, CHECK, ISSUE, BUSY} dm_fa_state_t;

    localparam int MATRIX_BITS  = 256;
    localparam int MATRIX_BYTES = 32;
    localparam logic [7:0] DEFAULT_SOF_BYTE = 8'hA5;

endpackage

// File: rtl/dm_gap_timer.sv
// Saturating cycle counter with synchronous clear; pulses expire on the cycle
// the count reaches MAX_COUNT. MAX_COUNT of 0 disables expiry entirely.
module dm_gap_timer #(
    parameter int unsigned MAX_COUNT = 5000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int unsigned W    = (MAX_COUNT < 1) ? 1 : $clog2(MAX_COUNT + 1);
    localparam int unsigned LAST = (MAX_COUNT > 0) ? MAX_COUNT - 1 : 0;
    localparam logic [W-1:0] LAST_V = W'(LAST);
    localparam logic [W-1:0] MAX_V  = W'(MAX_COUNT);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != MAX_V)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Expiry is flagged one cycle before the register itself would hold MAX_COUNT.
    assign expire = (MAX_COUNT != 0) && enable && !clear && (count_q == LAST_V);

endmodule

// File: rtl/dm_frame_assembler.sv
// Frames a byte stream as SOF + 32 payload bytes + XOR checksum and hands the
// assembled 256-bit matrix to the decoder, holding off until decode_done.
module dm_frame_assembler
    import fpga1_pkg::*;
#(
    parameter logic [7:0]  SOF_BYTE       = DEFAULT_SOF_BYTE,
    parameter int unsigned GAP_TIMEOUT    = 5000,
    parameter int unsigned DECODE_TIMEOUT = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [MATRIX_BITS-1:0] data_matrix_out,
    output logic                   dm_decode_en,
    input  logic                   decode_done,
    output logic                   busy,
    output logic                   crc_err,
    output logic                   timeout_err
);

    dm_fa_state_t state_q, state_d;
    logic [5:0]             count_q, count_d;
    logic [7:0]             accum_q, accum_d;
    logic [MATRIX_BITS-1:0] shadow_q, shadow_d;
    logic [MATRIX_BITS-1:0] matrix_q, matrix_d;
    logic                   ready_q, ready_d;
    logic                   decode_en_q, decode_en_d;
    logic                   busy_q, busy_d;
    logic                   crc_err_q, crc_err_d;
    logic                   timeout_q, timeout_d;

    logic xfer;
    logic gap_run, gap_expire;
    logic dec_run, dec_expire;

    assign xfer    = in_valid & ready_q;
    assign gap_run = ((state_q == COLLECT) || (state_q == CHECK)) && !xfer;
    assign dec_run = (state_q == BUSY) && !decode_done;

    dm_gap_timer #(.MAX_COUNT(GAP_TIMEOUT)) u_gap_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (!gap_run),
        .enable (gap_run),
        .expire (gap_expire)
    );

    dm_gap_timer #(.MAX_COUNT(DECODE_TIMEOUT)) u_decode_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (!dec_run),
        .enable (dec_run),
        .expire (dec_expire)
    );

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        accum_d     = accum_q;
        shadow_d    = shadow_q;
        matrix_d    = matrix_q;
        decode_en_d = 1'b0;
        crc_err_d   = 1'b0;
        timeout_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (xfer && (in_data == SOF_BYTE)) begin
                    state_d = COLLECT;
                    count_d = '0;
                    accum_d = '0;
                end
            end
            COLLECT: begin
                if (xfer) begin
                    shadow_d = {shadow_q[MATRIX_BITS-9:0], in_data};
                    accum_d  = accum_q ^ in_data;
                    count_d  = count_q + 6'd1;
                    if (count_q == 6'(MATRIX_BYTES - 1)) begin
                        state_d = CHECK;
                    end
                end else if (gap_expire) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end
            end
            CHECK: begin
                if (xfer) begin
                    if (in_data == accum_q) begin
                        matrix_d    = shadow_q;
                        decode_en_d = 1'b1;
                        state_d     = ISSUE;
                    end else begin
                        crc_err_d = 1'b1;
                        state_d   = IDLE;
                    end
                end else if (gap_expire) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end
            end
            ISSUE: begin
                state_d = BUSY;
            end
            BUSY: begin
                if (decode_done) begin
                    state_d = IDLE;
                end else if (dec_expire) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Handshake and busy are registered from the next state so nothing combinational reaches the ports.
        ready_d = (state_d == IDLE) || (state_d == COLLECT) || (state_d == CHECK);
        busy_d  = (state_d == ISSUE) || (state_d == BUSY);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            count_q     <= '0;
            accum_q     <= '0;
            shadow_q    <= '0;
            matrix_q    <= '0;
            ready_q     <= 1'b0;
            decode_en_q <= 1'b0;
            busy_q      <= 1'b0;
            crc_err_q   <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            accum_q     <= accum_d;
            shadow_q    <= shadow_d;
            matrix_q    <= matrix_d;
            ready_q     <= ready_d;
            decode_en_q <= decode_en_d;
            busy_q      <= busy_d;
            crc_err_q   <= crc_err_d;
            timeout_q   <= timeout_d;
        end
    end

    assign in_ready        = ready_q;
    assign data_matrix_out = matrix_q;
    assign dm_decode_en    = decode_en_q;
    assign busy            = busy_q;
    assign crc_err         = crc_err_q;
    assign timeout_err     = timeout_q;

endmodule
